// File: rtl/uart_frame_link.sv
// Link-layer engine between the UART byte interface and the miner core:
// assembles checksummed job frames, returns ACK/NAK and sends nonce result frames.
module uart_frame_link #(
   parameter int unsigned JOB_BYTES      = 76,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter logic [7:0]  ACK_BYTE       = 8'h06,
   parameter logic [7:0]  NAK_BYTE       = 8'h15,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   uart_received,
   input  logic [7:0]             uart_rx_byte,
   input  logic                   uart_recv_error,
   output logic                   uart_transmit,
   output logic [7:0]             uart_tx_byte,
   input  logic                   uart_is_transmitting,
   output logic [JOB_BYTES*8-1:0] job_data,
   output logic                   job_valid,
   input  logic                   result_valid,
   input  logic [31:0]            result_nonce,
   output logic                   result_ready,
   output logic [7:0]             frame_errors
);

   localparam int unsigned      IDX_W    = (JOB_BYTES > 1) ? $clog2(JOB_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(JOB_BYTES - 1);
   localparam logic [2:0]       LAST_RES = 3'd5;

   typedef enum logic [1:0] {R_HUNT, R_PAYLOAD, R_CHECK} rx_state_t;
   typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT_BUSY, T_WAIT_IDLE} tx_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   rx_state_t              rx_state, rx_next;
   logic [IDX_W-1:0]       byte_idx;
   logic [7:0]             xor_acc;
   logic [JOB_BYTES*8-1:0] shadow;
   logic [31:0]            idle_cnt;
   logic                   rx_active, rx_abort, rx_store;
   logic                   frame_good, frame_bad;

   tx_state_t              tx_state, tx_next;
   logic                   ack_pend, nak_pend, reply_pend;
   logic                   run_q;
   logic                   tx_reply, tx_reply_ack;
   logic [2:0]             tx_idx;
   logic [31:0]            nonce_q;
   logic                   take_reply, tx_last;
   logic [7:0]             cur_byte;

   assign rx_active  = (rx_state != R_HUNT);
   assign rx_abort   = rx_active && (uart_recv_error || (idle_cnt >= TIMEOUT_CYCLES));
   assign rx_store   = (rx_state == R_PAYLOAD) && uart_received && !rx_abort;
   assign reply_pend = ack_pend || nak_pend;

   // ---------------- RX frame FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_state <= R_HUNT;
      else        rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         R_HUNT:
            if (uart_received && uart_rx_byte == SYNC_BYTE) rx_next = R_PAYLOAD;
         R_PAYLOAD:
            if (rx_abort) rx_next = R_HUNT;
            else if (uart_received && byte_idx == LAST_IDX) rx_next = R_CHECK;
         R_CHECK:
            if (rx_abort || uart_received) rx_next = R_HUNT;
         default: rx_next = R_HUNT;
      endcase
   end

   always_comb begin
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      case (rx_state)
         R_PAYLOAD: frame_bad = rx_abort;
         R_CHECK:
            if (rx_abort) frame_bad = 1'b1;
            else if (uart_received) begin
               if (uart_rx_byte == xor_acc) frame_good = 1'b1;
               else                         frame_bad  = 1'b1;
            end
         default: ;
      endcase
   end

   assign job_valid = frame_good;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx     <= '0;
         xor_acc      <= '0;
         idle_cnt     <= '0;
         job_data     <= '0;
         frame_errors <= '0;
      end else begin
         if (uart_received || !rx_active) idle_cnt <= '0;
         else                             idle_cnt <= idle_cnt + 32'd1;
         if (rx_state == R_HUNT && uart_received && uart_rx_byte == SYNC_BYTE) begin
            byte_idx <= '0;
            xor_acc  <= '0;
         end else if (rx_store) begin
            byte_idx <= byte_idx + 1'b1;
            xor_acc  <= xor_acc ^ uart_rx_byte;
         end
         if (frame_good) job_data     <= shadow;
         if (frame_bad)  frame_errors <= sat_inc8(frame_errors);
      end
   end

   // Payload staging; only published to job_data once the checksum matches.
   always_ff @(posedge clk) begin
      if (rx_store) shadow[{byte_idx, 3'b000} +: 8] <= uart_rx_byte;
   end

   // ---------------- reply verdict (latest wins) ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_pend <= 1'b0;
         nak_pend <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (take_reply) begin
            ack_pend <= 1'b0;
            nak_pend <= 1'b0;
         end
         if (frame_good) begin
            ack_pend <= 1'b1;
            nak_pend <= 1'b0;
         end else if (frame_bad) begin
            ack_pend <= 1'b0;
            nak_pend <= 1'b1;
         end
      end
   end

   // ---------------- TX byte sequencer ----------------
   assign tx_last = tx_reply || (tx_idx == LAST_RES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_state <= T_IDLE;
      else        tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         T_IDLE:
            if (reply_pend || result_ready) tx_next = T_SEND;
         T_SEND:
            if (!uart_is_transmitting) tx_next = T_WAIT_BUSY;
         T_WAIT_BUSY:
            if (uart_is_transmitting) tx_next = T_WAIT_IDLE;
         T_WAIT_IDLE:
            if (!uart_is_transmitting) tx_next = tx_last ? T_IDLE : T_SEND;
         default: tx_next = T_IDLE;
      endcase
   end

   always_comb begin
      take_reply    = (tx_state == T_IDLE) && reply_pend;
      result_ready  = run_q && (tx_state == T_IDLE) && !reply_pend && result_valid;
      uart_transmit = (tx_state == T_SEND) && !uart_is_transmitting;
      case (tx_idx)
         3'd0:    cur_byte = SYNC_BYTE;
         3'd1:    cur_byte = nonce_q[7:0];
         3'd2:    cur_byte = nonce_q[15:8];
         3'd3:    cur_byte = nonce_q[23:16];
         3'd4:    cur_byte = nonce_q[31:24];
         default: cur_byte = nonce_q[7:0] ^ nonce_q[15:8] ^ nonce_q[23:16] ^ nonce_q[31:24];
      endcase
      if (tx_reply) cur_byte = tx_reply_ack ? ACK_BYTE : NAK_BYTE;
      uart_tx_byte = (tx_state != T_IDLE) ? cur_byte : 8'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_reply     <= 1'b0;
         tx_reply_ack <= 1'b0;
         tx_idx       <= '0;
      end else begin
         if (take_reply) begin
            tx_reply     <= 1'b1;
            tx_reply_ack <= ack_pend;
            tx_idx       <= '0;
         end else if (result_ready) begin
            tx_reply <= 1'b0;
            tx_idx   <= '0;
         end else if (tx_state == T_WAIT_IDLE && !uart_is_transmitting && !tx_last) begin
            tx_idx <= tx_idx + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (result_ready) nonce_q <= result_nonce;
   end

endmodule

// File: tb/tb_uart_frame_link.sv
// Directed bench for uart_frame_link: job frame vectors from a table plus
// hand-written timeout, abort, result-frame, overwrite and reset sequences.
module tb_uart_frame_link;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        uart_received, uart_recv_error, uart_is_transmitting;
   logic [7:0]  uart_rx_byte, uart_tx_byte, frame_errors;
   logic        uart_transmit, job_valid, result_valid, result_ready;
   logic [31:0] job_data, result_nonce;

   int n_checks = 0;
   int n_errors = 0;
   int jv_cnt   = 0;
   int acc_cnt  = 0;
   int acc_at_tx = 0;
   int busy_len = 3;
   logic [7:0] tx_q[$];

   uart_frame_link #(
      .JOB_BYTES(4), .SYNC_BYTE(8'hA5), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15),
      .TIMEOUT_CYCLES(32'd50)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .uart_received(uart_received), .uart_rx_byte(uart_rx_byte),
      .uart_recv_error(uart_recv_error),
      .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
      .uart_is_transmitting(uart_is_transmitting),
      .job_data(job_data), .job_valid(job_valid),
      .result_valid(result_valid), .result_nonce(result_nonce),
      .result_ready(result_ready), .frame_errors(frame_errors)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // UART transmitter model: goes busy after each request.
   initial begin
      uart_is_transmitting = 1'b0;
      forever begin
         @(negedge clk);
         if (uart_transmit === 1'b1) begin
            @(posedge clk); #1 uart_is_transmitting = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 uart_is_transmitting = 1'b0;
         end
      end
   end

   // Monitor sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (uart_transmit === 1'b1) begin
            tx_q.push_back(uart_tx_byte);
            chk("tx_while_busy", {31'd0, uart_is_transmitting}, 32'd0);
         end
         if (job_valid === 1'b1) jv_cnt++;
         if (result_valid === 1'b1 && result_ready === 1'b1) begin
            acc_cnt++;
            acc_at_tx = tx_q.size();
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1 uart_received = 1'b1; uart_rx_byte = b;
      @(posedge clk); #1 uart_received = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [63:0] bytes, input int n);
      for (int j = 0; j < n; j++) send_byte(bytes[j*8 +: 8]);
   endtask

   task automatic pulse_error();
      @(posedge clk); #1 uart_recv_error = 1'b1;
      @(posedge clk); #1 uart_recv_error = 1'b0;
   endtask

   task automatic wait_tx(input int n, input int budget, input string nm);
      int k = 0;
      while (tx_q.size() < n && k < budget) begin
         @(posedge clk); k++;
      end
      #1;
      chk({"wait_", nm}, {31'd0, tx_q.size() >= n}, 32'd1);
   endtask

   task automatic wait_acc(input int n, input int budget, input string nm);
      int k = 0;
      while (acc_cnt < n && k < budget) begin
         @(posedge clk); k++;
      end
      #1;
      chk({"wait_", nm}, {31'd0, acc_cnt >= n}, 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [63:0] bytes;
      logic [3:0]  n;
      logic [3:0]  jv;
      logic [31:0] data;
      logic [7:0]  tx;
      logic [7:0]  fe;
   } vec_t;

   vec_t vecs[4];
   logic [7:0] exp_res[6];
   logic [7:0] exp_mix[9];

   initial begin
      vecs[0] = {64'h0000_0404_0302_01A5, 4'd6, 4'd1, 32'h0403_0201, 8'h06, 8'd0};
      vecs[1] = {64'h0000_0504_0302_01A5, 4'd6, 4'd0, 32'h0403_0201, 8'h15, 8'd1};
      vecs[2] = {64'h4040_3020_10A5_2211, 4'd8, 4'd1, 32'h4030_2010, 8'h06, 8'd1};
      vecs[3] = {64'h0000_F000_FFA5_AAA5, 4'd6, 4'd1, 32'h00FF_A5AA, 8'h06, 8'd1};
      exp_res = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
      exp_mix = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08, 8'h06, 8'hA5, 8'h78};

      rst_n = 1'b0; uart_received = 1'b0; uart_rx_byte = 8'h00; uart_recv_error = 1'b0;
      result_valid = 1'b1; result_nonce = 32'h0;
      idle(3);
      chk("rst_transmit", {31'd0, uart_transmit}, 32'd0);
      chk("rst_tx_byte", {24'd0, uart_tx_byte}, 32'd0);
      chk("rst_job_data", job_data, 32'd0);
      chk("rst_job_valid", {31'd0, job_valid}, 32'd0);
      chk("rst_result_ready", {31'd0, result_ready}, 32'd0);
      chk("rst_frame_errors", {24'd0, frame_errors}, 32'd0);
      result_valid = 1'b0;
      rst_n = 1'b1;
      idle(3);

      for (int i = 0; i < 4; i++) begin
         tx_q.delete(); jv_cnt = 0;
         send_frame(vecs[i].bytes, int'(vecs[i].n));
         wait_tx(1, 200, $sformatf("v%0d_reply", i));
         idle(20);
         chk($sformatf("v%0d_job_valid_cnt", i), jv_cnt, {28'd0, vecs[i].jv});
         chk($sformatf("v%0d_job_data", i), job_data, vecs[i].data);
         chk($sformatf("v%0d_tx_byte", i), {24'd0, tx_q[0]}, {24'd0, vecs[i].tx});
         chk($sformatf("v%0d_tx_count", i), tx_q.size(), 32'd1);
         chk($sformatf("v%0d_frame_errors", i), {24'd0, frame_errors}, {24'd0, vecs[i].fe});
      end

      // No timeout and no error handling while hunting.
      tx_q.delete();
      idle(30);
      pulse_error();
      idle(80);
      chk("hunt_quiet_tx", tx_q.size(), 32'd0);
      chk("hunt_quiet_fe", {24'd0, frame_errors}, 32'd1);

      // Inter-byte timeout inside a frame.
      tx_q.delete(); jv_cnt = 0;
      send_byte(8'hA5); send_byte(8'h01);
      wait_tx(1, 200, "timeout_reply");
      idle(20);
      chk("timeout_tx", {24'd0, tx_q[0]}, 32'h15);
      chk("timeout_fe", {24'd0, frame_errors}, 32'd2);
      chk("timeout_job_data", job_data, 32'h00FF_A5AA);
      tx_q.delete();
      send_frame(vecs[0].bytes, 6);
      wait_tx(1, 200, "after_timeout");
      idle(20);
      chk("after_timeout_tx", {24'd0, tx_q[0]}, 32'h06);
      chk("after_timeout_jv", jv_cnt, 32'd1);
      chk("after_timeout_data", job_data, 32'h0403_0201);

      // Receive error aborts a frame.
      tx_q.delete();
      send_byte(8'hA5); send_byte(8'h01); pulse_error();
      wait_tx(1, 200, "rxerr_reply");
      idle(20);
      chk("rxerr_tx", {24'd0, tx_q[0]}, 32'h15);
      chk("rxerr_fe", {24'd0, frame_errors}, 32'd3);

      // Result frame.
      tx_q.delete(); acc_cnt = 0;
      result_nonce = 32'hDEADBEEF; result_valid = 1'b1;
      wait_acc(1, 50, "res_accept");
      @(posedge clk); #1 result_valid = 1'b0;
      wait_tx(6, 300, "res_frame");
      idle(30);
      chk("res_count", tx_q.size(), 32'd6);
      chk("res_accepts", acc_cnt, 32'd1);
      for (int j = 0; j < 6; j++)
         chk($sformatf("res_byte%0d", j), {24'd0, tx_q[j]}, {24'd0, exp_res[j]});

      // Two verdicts during a long result frame: only the latest (ACK) is sent.
      tx_q.delete(); acc_cnt = 0; busy_len = 12;
      result_nonce = 32'h0; result_valid = 1'b1;
      wait_acc(1, 50, "ovr_accept");
      @(posedge clk); #1 result_valid = 1'b0;
      send_frame(vecs[1].bytes, 6);
      send_frame(vecs[0].bytes, 6);
      wait_tx(7, 400, "ovr_frame");
      idle(60);
      chk("ovr_count", tx_q.size(), 32'd7);
      chk("ovr_reply", {24'd0, tx_q[6]}, 32'h06);
      chk("ovr_fe", {24'd0, frame_errors}, 32'd4);
      busy_len = 3;

      // frame_errors saturation.
      for (int j = 0; j < 260; j++) begin
         send_byte(8'hA5); pulse_error();
      end
      idle(80);
      chk("sat_fe", {24'd0, frame_errors}, 32'hFF);

      // Reply during a result frame waits; next result waits for the reply.
      tx_q.delete(); acc_cnt = 0; jv_cnt = 0;
      result_nonce = 32'h12345678; result_valid = 1'b1;
      wait_acc(1, 50, "mix_accept1");
      send_frame(vecs[0].bytes, 6);
      wait_acc(2, 400, "mix_accept2");
      @(posedge clk); #1 result_valid = 1'b0;
      chk("mix_accept2_after_reply", acc_at_tx, 32'd7);
      chk("mix_jv", jv_cnt, 32'd1);
      wait_tx(9, 300, "mix_frame");
      for (int j = 0; j < 9; j++)
         chk($sformatf("mix_byte%0d", j), {24'd0, tx_q[j]}, {24'd0, exp_mix[j]});

      // Reset in the middle of a byte.
      result_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_transmit", {31'd0, uart_transmit}, 32'd0);
      chk("mid_rst_tx_byte", {24'd0, uart_tx_byte}, 32'd0);
      chk("mid_rst_job_data", job_data, 32'd0);
      chk("mid_rst_job_valid", {31'd0, job_valid}, 32'd0);
      chk("mid_rst_result_ready", {31'd0, result_ready}, 32'd0);
      chk("mid_rst_fe", {24'd0, frame_errors}, 32'd0);
      result_valid = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(20);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_frame_link.md
Name: uart_frame_link

Overview:
Byte-level link-layer engine on the fabric side of the UART byte interface, between the UART and the miner core. It consumes received bytes and assembles checksummed job frames from the host. It drives the UART transmit handshake to return ACK/NAK bytes and checksummed result frames carrying found nonces. One instance sits between the UART and the hashing core.

Parameters:
JOB_BYTES, 76, payload bytes per job frame (≥1).
SYNC_BYTE, 8'hA5, frame start marker (both directions).
ACK_BYTE, 8'h06, sent after a good job frame.
NAK_BYTE, 8'h15, sent after a bad or aborted job frame.
TIMEOUT_CYCLES, 32'd1000000, max clk cycles between bytes inside a frame.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
uart_received  in  1  one-cycle strobe; uart_rx_byte valid
uart_rx_byte  in  8  received byte
uart_recv_error  in  1  one-cycle UART framing error strobe
uart_transmit  out  1  one-cycle request to send uart_tx_byte
uart_tx_byte  out  8  byte to send; stable while uart_transmit=1
uart_is_transmitting  in  1  UART tx busy
job_data  out  JOB_BYTES*8  last good payload; byte 0 in bits [7:0]
job_valid  out  1  one-cycle strobe; job_data updated this cycle
result_valid  in  1  core offers a nonce
result_nonce  in  32  nonce to report
result_ready  out  1  result accepted when result_valid && result_ready
frame_errors  out  8  saturating count of bad/aborted job frames

Behaviour:
- Reset (async, rst_n=0): all outputs 0, job_data 0, frame_errors 0; RX in R_HUNT, TX in T_IDLE; pending flags cleared. A reset mid-frame discards the partial payload, and any in-flight UART byte is abandoned.
- RX FSM:
  - R_HUNT: ignore all bytes except SYNC_BYTE. On SYNC_BYTE: byte_idx=0, xor_acc=0 → R_PAYLOAD.
  - R_PAYLOAD: on each received byte, store it to shadow[byte_idx] and update xor_acc ^= byte. After byte JOB_BYTES-1 → R_CHECK.
  - R_CHECK: the next byte is the checksum. If it equals xor_acc, copy shadow to job_data, pulse job_valid the same cycle, and set ack_pend. Otherwise set nak_pend and increment frame_errors. Return to R_HUNT.
  - job_data changes only on a good checksum; it is never partially updated.
- Abort: uart_recv_error, or an inter-byte idle counter reaching TIMEOUT_CYCLES, while in R_PAYLOAD/R_CHECK causes nak_pend, frame_errors+1, → R_HUNT. The idle counter resets on every uart_received. It does not run in R_HUNT. uart_recv_error in R_HUNT is ignored.
- frame_errors saturates at 8'hFF.
- A new ACK/NAK request while one is still pending overwrites it; the most recent verdict wins and only one reply is sent.
- TX byte sequencer:
  - T_IDLE: priority is reply (ack_pend/nak_pend) first, then result.
  - Reply: a single byte.
  - Result: result_ready=1 for exactly one cycle in T_IDLE, and only when no reply is pending. On acceptance, latch the nonce. Send SYNC_BYTE, nonce[7:0], [15:8], [23:16], [31:24], then the XOR of the 4 nonce bytes (6 bytes total).
- Per-byte handshake (T_SEND → T_WAIT_BUSY → T_WAIT_IDLE):
  - T_SEND: drive uart_tx_byte and pulse uart_transmit for one cycle, only when uart_is_transmitting=0.
  - T_WAIT_BUSY: wait for uart_is_transmitting=1.
  - T_WAIT_IDLE: wait for it to return to 0, then advance to the next byte or go to T_IDLE.
- A reply arriving mid-result-frame waits until the result frame completes; frames are never interleaved.
- RX and TX run concurrently and independently. job_valid and result handshakes in the same cycle are legal.
- Latency: job_valid is asserted in the same cycle as the uart_received strobe of the checksum byte. The first uart_transmit is no earlier than 1 cycle after the pending flag sets.

Test Plan:
- JOB_BYTES=4. RX A5,01,02,03,04,04 → job_valid one pulse, job_data=32'h04030201, TX byte 06, frame_errors=0.
- Same frame with checksum 05 → no job_valid, job_data unchanged, TX 15, frame_errors=1.
- Bytes 11,22 before A5, then a good frame → leading bytes ignored, frame accepted normally.
- A5,01 followed by no more bytes for TIMEOUT_CYCLES (set to 50) → TX 15, frame_errors=1. A following good frame is accepted.
- result_nonce=32'hDEADBEEF → TX A5,EF,BE,AD,DE,22. Exactly 6 uart_transmit pulses, each only while uart_is_transmitting=0.
- result_valid held high while a good job frame completes mid-result → result frame finishes, then 06 is sent. The next result waits until after 06. Then assert rst_n=0 mid-byte → all outputs 0 immediately.
